// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI4 master port (29-bit address, 512-bit data)
// between an instruction-fetch client (read-only, word) and an exec client
// (byte/word load/store). Only one single-beat transaction is in flight at a
// time, and clients are granted round-robin.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter logic [3:0] AXI_ID_BASE = 4'h0
) (
  input  logic         clk,
  input  logic         rstn,
  // fetch client
  input  logic         req_valid0,
  input  logic [28:0]  req_addr0,
  output logic         req_ready0,
  output logic         resp_valid0,
  // exec client
  input  logic         req_valid1,
  input  logic         req_we1,
  input  logic [2:0]   req_size1,
  input  logic [28:0]  req_addr1,
  input  logic [31:0]  req_wdata1,
  output logic         req_ready1,
  output logic         resp_valid1,
  // shared response
  output logic [31:0]  resp_rdata,
  output logic         resp_err,
  // AXI AR
  output logic [28:0]  araddr,
  output logic [2:0]   arsize,
  output logic [3:0]   arid,
  output logic         arvalid,
  input  logic         arready,
  output logic [1:0]   arburst,
  output logic [7:0]   arlen,
  output logic [3:0]   arcache,
  output logic         arlock,
  output logic [2:0]   arprot,
  output logic [3:0]   arqos,
  // AXI R
  input  logic [511:0] rdata,
  input  logic [3:0]   rid,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AXI AW
  output logic [28:0]  awaddr,
  output logic [2:0]   awsize,
  output logic [3:0]   awid,
  output logic         awvalid,
  input  logic         awready,
  output logic [1:0]   awburst,
  output logic [7:0]   awlen,
  output logic [3:0]   awcache,
  output logic         awlock,
  output logic [2:0]   awprot,
  output logic [3:0]   awqos,
  // AXI W
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI B
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t        state_q;
  logic          last_q;
  logic          gnt_q;
  logic          byte_q;
  logic [5:0]    lane_q;
  logic [28:0]   araddr_q, awaddr_q;
  logic [2:0]    arsize_q, awsize_q;
  logic [3:0]    arid_q, awid_q;
  logic          arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
  logic [511:0]  wdata_q;
  logic [63:0]   wstrb_q;
  logic          req_ready0_q, req_ready1_q, resp_valid0_q, resp_valid1_q;
  logic [31:0]   resp_rdata_q;
  logic          resp_err_q;

  logic          gnt_any_d;
  logic          gnt_idx_d;
  logic          gnt_we_d;
  logic          gnt_byte_d;
  logic [28:0]   gnt_raw_d;
  logic [28:0]   gnt_addr_d;
  logic          aw_done_d;
  logic          w_done_d;

  // IDs are fixed by the single-outstanding rule; rlast is always 1 for len=0.
  logic unused_axi;
  assign unused_axi = ^{rid, bid, rlast};

  // Pick the 32-bit word or sign-extended byte out of a 512-bit beat.
  function automatic logic [31:0] lane_extract(input logic [511:0] data,
                                               input logic [5:0]   a,
                                               input logic         is_byte);
    logic [7:0] b;
    if (is_byte) begin
      b = data[a*8 +: 8];
      return {{24{b[7]}}, b};
    end
    return data[a[5:2]*32 +: 32];
  endfunction

  // Place store data on its lane; all other bits are zero.
  function automatic logic [511:0] lane_wdata(input logic [31:0] d,
                                              input logic [5:0]  a,
                                              input logic        is_byte);
    logic [511:0] w;
    w = '0;
    if (is_byte) w[a*8 +: 8] = d[7:0];
    else         w[a[5:2]*32 +: 32] = d;
    return w;
  endfunction

  // Byte strobes matching lane_wdata.
  function automatic logic [63:0] lane_wstrb(input logic [5:0] a,
                                             input logic       is_byte);
    logic [63:0] s;
    s = '0;
    if (is_byte) s[a] = 1'b1;
    else         s[a[5:2]*4 +: 4] = 4'hf;
    return s;
  endfunction

  // Round-robin choice and decode of the winning request.
  always_comb begin
    gnt_any_d = req_valid0 | req_valid1;
    gnt_idx_d = 1'b0;
    if (req_valid0 && req_valid1) gnt_idx_d = ~last_q;
    else if (req_valid1)          gnt_idx_d = 1'b1;
    gnt_we_d   = gnt_idx_d & req_we1;
    gnt_byte_d = gnt_idx_d & (req_size1 == 3'b000);
    gnt_raw_d  = gnt_idx_d ? req_addr1 : req_addr0;
    gnt_addr_d = gnt_byte_d ? gnt_raw_d : {gnt_raw_d[28:2], 2'b00};
    // A bvalid only counts once both AW and W have handshaken (this cycle or earlier).
    aw_done_d  = !awvalid_q || awready;
    w_done_d   = !wvalid_q  || wready;
  end

  // Transaction FSM with all AXI and client outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      last_q        <= 1'b1;
      gnt_q         <= 1'b0;
      byte_q        <= 1'b0;
      lane_q        <= '0;
      araddr_q      <= '0;
      awaddr_q      <= '0;
      arsize_q      <= 3'b010;
      awsize_q      <= 3'b010;
      arid_q        <= '0;
      awid_q        <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      wlast_q       <= 1'b0;
      bready_q      <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      req_ready0_q  <= 1'b0;
      req_ready1_q  <= 1'b0;
      resp_valid0_q <= 1'b0;
      resp_valid1_q <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      req_ready0_q  <= 1'b0;
      req_ready1_q  <= 1'b0;
      resp_valid0_q <= 1'b0;
      resp_valid1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_any_d) begin
            gnt_q  <= gnt_idx_d;
            last_q <= gnt_idx_d;
            byte_q <= gnt_byte_d;
            lane_q <= gnt_addr_d[5:0];
            if (gnt_idx_d) req_ready1_q <= 1'b1;
            else           req_ready0_q <= 1'b1;
            if (gnt_we_d) begin
              awaddr_q  <= gnt_addr_d;
              awsize_q  <= gnt_byte_d ? 3'b000 : 3'b010;
              awid_q    <= AXI_ID_BASE + {3'b000, gnt_idx_d};
              wdata_q   <= lane_wdata(req_wdata1, gnt_addr_d[5:0], gnt_byte_d);
              wstrb_q   <= lane_wstrb(gnt_addr_d[5:0], gnt_byte_d);
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              wlast_q   <= 1'b1;
              bready_q  <= 1'b1;
              state_q   <= S_WR;
            end else begin
              araddr_q  <= gnt_addr_d;
              arsize_q  <= gnt_byte_d ? 3'b000 : 3'b010;
              arid_q    <= AXI_ID_BASE + {3'b000, gnt_idx_d};
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
              state_q   <= S_RD;
            end
          end
        end
        S_RD: begin
          if (arvalid_q && arready) arvalid_q <= 1'b0;
          if (rvalid && rready_q) begin
            rready_q     <= 1'b0;
            resp_rdata_q <= lane_extract(rdata, lane_q, byte_q);
            resp_err_q   <= |rresp;
            state_q      <= S_RESP;
          end
        end
        S_WR: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
          end
          if (bvalid && bready_q && aw_done_d && w_done_d) begin
            bready_q   <= 1'b0;
            resp_err_q <= |bresp;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          if (gnt_q) resp_valid1_q <= 1'b1;
          else       resp_valid0_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready0  = req_ready0_q;
  assign req_ready1  = req_ready1_q;
  assign resp_valid0 = resp_valid0_q;
  assign resp_valid1 = resp_valid1_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arid    = arid_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awid    = awid_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wlast_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arcache = 4'b0011;
  assign awcache = 4'b0011;
  assign arlock  = 1'b0;
  assign awlock  = 1'b0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;
  assign arqos   = 4'd0;
  assign awqos   = 4'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// byte-array memory model and a round-robin grant model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         req_valid0, req_valid1, req_we1;
  logic [28:0]  req_addr0, req_addr1;
  logic [2:0]   req_size1;
  logic [31:0]  req_wdata1;
  logic         req_ready0, req_ready1, resp_valid0, resp_valid1, resp_err;
  logic [31:0]  resp_rdata;
  logic [28:0]  araddr, awaddr;
  logic [2:0]   arsize, awsize, arprot, awprot;
  logic [3:0]   arid, awid, arcache, awcache, arqos, awqos;
  logic [1:0]   arburst, awburst;
  logic [7:0]   arlen, awlen;
  logic         arlock, awlock;
  logic         arvalid, arready, rready, rvalid, rlast;
  logic [511:0] rdata, wdata;
  logic [3:0]   rid, bid;
  logic [1:0]   rresp, bresp;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [63:0]  wstrb;

  // slave: automatic zero-wait mode or manually driven
  logic         s_auto;
  logic         m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [1:0]   m_rresp, m_bresp;
  logic [511:0] m_rdata;
  logic [511:0] smem [0:3];
  logic         mem_ld;
  logic [1:0]   mem_ld_idx;
  logic [511:0] mem_ld_data;

  logic [7:0]   ref_mem [0:255];
  logic         last_m;
  int           tests_run, tests_failed;

  assign arready = s_auto ? 1'b1 : m_arready;
  assign rvalid  = s_auto ? arvalid : m_rvalid;
  assign rdata   = s_auto ? smem[araddr[7:6]] : m_rdata;
  assign rresp   = s_auto ? 2'b00 : m_rresp;
  assign rlast   = 1'b1;
  assign rid     = 4'd0;
  assign awready = s_auto ? 1'b1 : m_awready;
  assign wready  = s_auto ? 1'b1 : m_wready;
  assign bvalid  = s_auto ? bready : m_bvalid;
  assign bresp   = s_auto ? 2'b00 : m_bresp;
  assign bid     = 4'd0;

  always @(posedge clk) begin
    if (mem_ld) smem[mem_ld_idx] <= mem_ld_data;
    else if (s_auto && wvalid && wready)
      for (int i = 0; i < 64; i++)
        if (wstrb[i]) smem[awaddr[7:6]][i*8 +: 8] <= wdata[i*8 +: 8];
  end

  mem_arbiter #(.AXI_ID_BASE(4'h0)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid0(req_valid0), .req_addr0(req_addr0), .req_ready0(req_ready0), .resp_valid0(resp_valid0),
    .req_valid1(req_valid1), .req_we1(req_we1), .req_size1(req_size1), .req_addr1(req_addr1),
    .req_wdata1(req_wdata1), .req_ready1(req_ready1), .resp_valid1(resp_valid1),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arsize(arsize), .arid(arid), .arvalid(arvalid), .arready(arready),
    .arburst(arburst), .arlen(arlen), .arcache(arcache), .arlock(arlock), .arprot(arprot), .arqos(arqos),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awid(awid), .awvalid(awvalid), .awready(awready),
    .awburst(awburst), .awlen(awlen), .awcache(awcache), .awlock(awlock), .awprot(awprot), .awqos(awqos),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [28:0] a, input logic is_byte);
    int b;
    b = int'(a[7:0]);
    if (is_byte) return {{24{ref_mem[b][7]}}, ref_mem[b]};
    b = b & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_store(input logic [28:0] a, input logic is_byte, input logic [31:0] d);
    int b;
    b = int'(a[7:0]);
    if (is_byte) ref_mem[b] = d[7:0];
    else begin
      b = b & ~3;
      for (int i = 0; i < 4; i++) ref_mem[b+i] = d[i*8 +: 8];
    end
  endtask

  // ---------------- utilities ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_line(input int idx, input logic [511:0] d);
    mem_ld = 1'b1; mem_ld_idx = 2'(idx); mem_ld_data = d;
    step();
    mem_ld = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0; req_we1 = 1'b0; req_size1 = 3'b010;
    req_addr0 = '0; req_addr1 = '0; req_wdata1 = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    m_rresp = 2'b00; m_bresp = 2'b00; m_rdata = '0;
    step(); step();
    rstn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    s_auto = 1'b0;
    do_reset();
    tests_run++;
    if ({arvalid, rready, awvalid, wvalid, wlast, bready, req_ready0, req_ready1, resp_valid0, resp_valid1} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_valids: got %b want 0", {arvalid, rready, awvalid, wvalid, wlast, bready, req_ready0, req_ready1, resp_valid0, resp_valid1});
    end
    tests_run++;
    if ({araddr, awaddr} !== 58'd0) begin
      tests_failed++; $display("FAIL reset_addr: got araddr=%h awaddr=%h want 0", araddr, awaddr);
    end
    tests_run++;
    if (wstrb !== 64'd0 || wdata !== 512'd0 || resp_rdata !== 32'd0) begin
      tests_failed++; $display("FAIL reset_data: got wstrb=%h resp_rdata=%h want 0", wstrb, resp_rdata);
    end
    tests_run++;
    if (arsize !== 3'b010 || awsize !== 3'b010) begin
      tests_failed++; $display("FAIL reset_size: got arsize=%b awsize=%b want 010", arsize, awsize);
    end
    tests_run++;
    if ({arburst, awburst, arlen, awlen, arcache, awcache, arlock, awlock, arprot, awprot, arqos, awqos} !==
        {2'b01, 2'b01, 8'd0, 8'd0, 4'b0011, 4'b0011, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0}) begin
      tests_failed++; $display("FAIL axi_constants: got burst=%b/%b cache=%b/%b", arburst, awburst, arcache, awcache);
    end
  endtask

  task automatic test_fetch();
    logic [511:0] line;
    for (int i = 0; i < 16; i++) line[i*32 +: 32] = $urandom;
    line[95:64] = 32'hDEADBEEF;
    s_auto = 1'b1;
    load_line(1, line);
    req_valid0 = 1'b1; req_addr0 = 29'h48;
    step();
    tests_run++;
    if (req_ready0 !== 1'b1 || arvalid !== 1'b1 || araddr !== 29'h48 || arsize !== 3'b010 || arid !== 4'd0) begin
      tests_failed++;
      $display("FAIL fetch_ar: got ready=%b arvalid=%b araddr=%h arsize=%b arid=%h want 1 1 48 010 0", req_ready0, arvalid, araddr, arsize, arid);
    end
    req_valid0 = 1'b0;
    step();
    tests_run++;
    if (resp_valid0 !== 1'b0) begin tests_failed++; $display("FAIL fetch_early_resp: got %b want 0", resp_valid0); end
    step();
    tests_run++;
    if (resp_valid0 !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_resp: got valid=%b rdata=%h err=%b want 1 deadbeef 0", resp_valid0, resp_rdata, resp_err);
    end
    step();
    tests_run++;
    if (resp_valid0 !== 1'b0) begin tests_failed++; $display("FAIL fetch_resp_pulse: got %b want 0", resp_valid0); end
  endtask

  task automatic test_store_byte();
    logic [511:0] ew;
    ew = '0; ew[47:40] = 8'hA5;
    s_auto = 1'b1;
    req_valid1 = 1'b1; req_we1 = 1'b1; req_size1 = 3'b000; req_addr1 = 29'h105; req_wdata1 = 32'h000000A5;
    step();
    tests_run++;
    if (req_ready1 !== 1'b1 || awaddr !== 29'h105 || awsize !== 3'b000 || awid !== 4'd1) begin
      tests_failed++;
      $display("FAIL store_byte_aw: got ready=%b awaddr=%h awsize=%b awid=%h want 1 105 000 1", req_ready1, awaddr, awsize, awid);
    end
    tests_run++;
    if (wstrb !== 64'h20 || wdata !== ew || {awvalid, wvalid, wlast, bready} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL store_byte_w: got wstrb=%h ctl=%b wdata=%h", wstrb, {awvalid, wvalid, wlast, bready}, wdata);
    end
    req_valid1 = 1'b0;
    step(); step();
    tests_run++;
    if (resp_valid1 !== 1'b1 || resp_err !== 1'b0) begin
      tests_failed++; $display("FAIL store_byte_resp: got valid=%b err=%b want 1 0", resp_valid1, resp_err);
    end
  endtask

  task automatic test_early_bvalid();
    logic [511:0] ew;
    ew = '0; ew[63:32] = 32'h12345678;
    s_auto = 1'b0;
    req_valid1 = 1'b1; req_we1 = 1'b1; req_size1 = 3'b010; req_addr1 = 29'h1C6; req_wdata1 = 32'h12345678;
    step();
    tests_run++;
    if (req_ready1 !== 1'b1 || awaddr !== 29'h1C4 || wstrb !== 64'hF0 || wdata !== ew) begin
      tests_failed++;
      $display("FAIL store_word_lane: got ready=%b awaddr=%h wstrb=%h want 1 1c4 f0", req_ready1, awaddr, wstrb);
    end
    req_valid1 = 1'b0; m_bvalid = 1'b1;
    step();
    tests_run++;
    if ({resp_valid1, awvalid, wvalid, bready} !== 4'b0111) begin
      tests_failed++; $display("FAIL early_b_c1: got %b want 0111", {resp_valid1, awvalid, wvalid, bready});
    end
    m_awready = 1'b1;
    step();
    tests_run++;
    if ({resp_valid1, awvalid, wvalid, bready} !== 4'b0011) begin
      tests_failed++; $display("FAIL early_b_c2: got %b want 0011", {resp_valid1, awvalid, wvalid, bready});
    end
    m_awready = 1'b0; m_bvalid = 1'b0;
    step();
    step();
    tests_run++;
    if ({resp_valid1, awvalid, wvalid, bready} !== 4'b0011) begin
      tests_failed++; $display("FAIL early_b_c4: got %b want 0011", {resp_valid1, awvalid, wvalid, bready});
    end
    m_wready = 1'b1;
    step();
    tests_run++;
    if ({resp_valid1, awvalid, wvalid, bready} !== 4'b0001) begin
      tests_failed++; $display("FAIL early_b_c5: got %b want 0001", {resp_valid1, awvalid, wvalid, bready});
    end
    m_wready = 1'b0; m_bvalid = 1'b1;
    step();
    tests_run++;
    if ({resp_valid1, awvalid, wvalid, bready} !== 4'b0000) begin
      tests_failed++; $display("FAIL early_b_c6: got %b want 0000", {resp_valid1, awvalid, wvalid, bready});
    end
    m_bvalid = 1'b0;
    step();
    tests_run++;
    if (resp_valid1 !== 1'b1 || resp_err !== 1'b0) begin
      tests_failed++; $display("FAIL early_b_resp: got valid=%b err=%b want 1 0", resp_valid1, resp_err);
    end
  endtask

  task automatic test_load_byte_err();
    s_auto = 1'b0;
    req_valid1 = 1'b1; req_we1 = 1'b0; req_size1 = 3'b000; req_addr1 = 29'h3F;
    step();
    tests_run++;
    if (arvalid !== 1'b1 || araddr !== 29'h3F || arsize !== 3'b000 || arid !== 4'd1) begin
      tests_failed++;
      $display("FAIL load_byte_ar: got arvalid=%b araddr=%h arsize=%b arid=%h want 1 3f 000 1", arvalid, araddr, arsize, arid);
    end
    req_valid1 = 1'b0;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rresp = 2'b10; m_rdata = {8'h80, {63{8'h11}}};
    step();
    m_arready = 1'b0; m_rvalid = 1'b0; m_rresp = 2'b00;
    step();
    tests_run++;
    if (resp_valid1 !== 1'b1 || resp_rdata !== 32'hFFFFFF80 || resp_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_byte_err: got valid=%b rdata=%h err=%b want 1 ffffff80 1", resp_valid1, resp_rdata, resp_err);
    end
  endtask

  task automatic test_reset_mid_rd();
    logic stray;
    s_auto = 1'b0;
    req_valid0 = 1'b1; req_addr0 = 29'h80;
    step();
    tests_run++;
    if (arvalid !== 1'b1 || rready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_rd_setup: got arvalid=%b rready=%b want 1 1", arvalid, rready);
    end
    req_valid0 = 1'b0; rstn = 1'b0;
    step();
    tests_run++;
    if ({arvalid, rready, resp_valid0, resp_valid1} !== 4'b0000) begin
      tests_failed++; $display("FAIL mid_rd_reset: got %b want 0000", {arvalid, rready, resp_valid0, resp_valid1});
    end
    rstn = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (resp_valid0 || resp_valid1 || arvalid) stray = 1'b1;
    end
    tests_run++;
    if (stray !== 1'b0) begin tests_failed++; $display("FAIL mid_rd_stray: got activity=%b want 0", stray); end
    s_auto = 1'b1;
    req_valid0 = 1'b1; req_addr0 = 29'h4A;
    step();
    tests_run++;
    if (req_ready0 !== 1'b1 || araddr !== 29'h48) begin
      tests_failed++; $display("FAIL after_reset_grant: got ready=%b araddr=%h want 1 48", req_ready0, araddr);
    end
    req_valid0 = 1'b0;
    step(); step();
    tests_run++;
    if (resp_valid0 !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL after_reset_resp: got valid=%b rdata=%h want 1 deadbeef", resp_valid0, resp_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp_g, seen, both;
    s_auto = 1'b1;
    do_reset();
    req_we1 = 1'b0; req_size1 = 3'b010; req_addr0 = 29'h10; req_addr1 = 29'h20;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    exp_g = 1'b0; both = 1'b0;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (req_ready0 && req_ready1) both = 1'b1;
        if (req_ready0 || req_ready1) begin seen = 1'b1; break; end
      end
      tests_run++;
      if ({req_ready1, req_ready0} !== (exp_g ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got ready1/0=%b want %b (seen=%b)", n, {req_ready1, req_ready0}, exp_g ? 2'b10 : 2'b01, seen);
      end
      if (exp_g) req_valid1 = 1'b0; else req_valid0 = 1'b0;
      step();
      if (req_ready0 && req_ready1) both = 1'b1;
      if (exp_g) req_valid1 = 1'b1; else req_valid0 = 1'b1;
      exp_g = ~exp_g;
    end
    tests_run++;
    if (both !== 1'b0) begin tests_failed++; $display("FAIL rr_exclusive: got dual ready=%b want 0", both); end
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_random();
    logic         p0, p1, we1, g, seen, is_byte;
    logic [28:0]  a0, a1;
    logic [2:0]   sz1;
    logic [31:0]  wd1, exp;
    logic [511:0] line;
    s_auto = 1'b1;
    do_reset();
    last_m = 1'b1;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) line[i*32 +: 32] = $urandom;
      load_line(l, line);
      for (int b = 0; b < 64; b++) ref_mem[l*64 + b] = line[b*8 +: 8];
    end
    p0 = 1'b0; p1 = 1'b0; we1 = 1'b0; sz1 = 3'b010; a0 = '0; a1 = '0; wd1 = '0;
    for (int n = 0; n < 150; n++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; a0 = 29'($urandom); end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1'b1; we1 = 1'($urandom_range(0, 1)); a1 = 29'($urandom); wd1 = $urandom;
        case ($urandom_range(0, 3))
          0:       sz1 = 3'b000;
          3:       sz1 = 3'b011;
          default: sz1 = 3'b010;
        endcase
      end
      if (!p0 && !p1) begin p0 = 1'b1; a0 = 29'($urandom); end
      req_valid0 = p0; req_addr0 = a0;
      req_valid1 = p1; req_we1 = we1; req_size1 = sz1; req_addr1 = a1; req_wdata1 = wd1;
      g = (p0 && p1) ? ~last_m : p1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (req_ready0 || req_ready1) begin seen = 1'b1; break; end
      end
      tests_run++;
      if (!seen || {req_ready1, req_ready0} !== (g ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("FAIL rand_grant%0d: got ready1/0=%b want %b (seen=%b)", n, {req_ready1, req_ready0}, g ? 2'b10 : 2'b01, seen);
        return;
      end
      last_m = g;
      if (g) begin req_valid1 = 1'b0; p1 = 1'b0; end
      else   begin req_valid0 = 1'b0; p0 = 1'b0; end
      is_byte = g && (sz1 == 3'b000);
      exp = '0;
      if (!g)       exp = ref_load(a0, 1'b0);
      else if (we1) ref_store(a1, is_byte, wd1);
      else          exp = ref_load(a1, is_byte);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (resp_valid0 || resp_valid1) begin seen = 1'b1; break; end
      end
      tests_run++;
      if (!seen || {resp_valid1, resp_valid0} !== (g ? 2'b10 : 2'b01) || resp_err !== 1'b0 ||
          (!(g && we1) && resp_rdata !== exp)) begin
        tests_failed++;
        $display("FAIL rand_resp%0d: got valid1/0=%b rdata=%h err=%b want %b %h 0 (client %0d we %b)",
                 n, {resp_valid1, resp_valid0}, resp_rdata, resp_err, g ? 2'b10 : 2'b01, exp, g, g && we1);
      end
    end
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    repeat (4) step();
    for (int l = 0; l < 4; l++) begin
      for (int b = 0; b < 64; b++) line[b*8 +: 8] = ref_mem[l*64 + b];
      tests_run++;
      if (smem[l] !== line) begin
        tests_failed++; $display("FAIL rand_mem_line%0d: got %h want %h", l, smem[l], line);
      end
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rstn = 1'b0; s_auto = 1'b0; mem_ld = 1'b0; mem_ld_idx = '0; mem_ld_data = '0;
    test_reset();
    test_fetch();
    test_store_byte();
    test_early_bvalid();
    test_load_byte_err();
    test_reset_mid_rd();
    test_round_robin();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single AXI4 master port (29-bit address, 512-bit data) between two requesters.
  - Requester 0: instruction fetch, read-only.
  - Requester 1: exec unit, load/store.
- Converts a simple per-client request/response interface into single-beat AXI4 transactions.
- Handles 32-bit and 8-bit lane placement and extraction within the 512-bit bus.
- One transaction outstanding at a time; grants between clients are round-robin.

Parameters:
- AXI_ID_BASE, 4'h0: arid/awid = AXI_ID_BASE + granted client index.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- req_valid0  input  1  fetch read request; held until req_ready0
- req_addr0  input  29  fetch byte address (word access)
- req_ready0  output  1  one-cycle grant pulse to fetch
- resp_valid0  output  1  one-cycle pulse; resp_rdata valid for fetch
- req_valid1  input  1  exec request; held until req_ready1
- req_we1  input  1  1 = store, 0 = load
- req_size1  input  3  3'b000 = byte, 3'b010 = word
- req_addr1  input  29  exec byte address
- req_wdata1  input  32  store data (byte in [7:0])
- req_ready1  output  1  one-cycle grant pulse to exec
- resp_valid1  output  1  one-cycle pulse; load data valid or store complete
- resp_rdata  output  32  load/fetch data, shared by both clients
- resp_err  output  1  valid with resp_valid*; 1 if rresp/bresp != 2'b00
- AXI AR: araddr 29 out, arsize 3 out, arid 4 out, arvalid out, arready in
- AXI R: rdata 512 in, rid 4 in, rresp 2 in, rlast in, rvalid in, rready out
- AXI AW: awaddr 29 out, awsize 3 out, awid 4 out, awvalid out, awready in
- AXI W: wdata 512 out, wstrb 64 out, wlast out, wvalid out, wready in
- AXI B: bid 4 in, bresp 2 in, bvalid in, bready out
- AXI constant outputs: ar/awburst=2'b01, ar/awlen=0, ar/awcache=4'b0011, ar/awlock=0, ar/awprot=0, ar/awqos=0

Behaviour:
- Reset values:
  - All valid, ready, req_ready* and resp_valid* outputs are 0.
  - Addresses, wdata, wstrb and resp_rdata are 0.
  - arsize and awsize are 3'b010.
  - Round-robin pointer last = 1, so fetch wins the first tie.
  - State is IDLE.
  - A reset in any state abandons the transaction: no resp pulse is issued and all valids drop on the next edge.
- State IDLE:
  - If exactly one req_valid is high, grant that client.
  - If both are high, grant the client != last, then set last to the granted client.
  - On grant, at the next edge:
    - Latch the request fields.
    - Pulse req_ready for that client for one cycle.
    - Load: enter RD with arvalid=1 and rready=1.
    - Store: enter WR with awvalid=1, wvalid=1, wlast=1 and bready=1.
  - Word accesses force address bits [1:0] to 0.
- State RD:
  - Clear arvalid on arready&&arvalid.
  - On rvalid&&rready (rlast expected 1):
    - Clear rready.
    - Word: resp_rdata = rdata[addr[5:2]*32 +: 32].
    - Byte: resp_rdata = sign-extended rdata[addr[5:0]*8 +: 8].
    - resp_err = |rresp.
    - Enter RESP.
  - rvalid arriving in the same cycle as arready is legal and is handled in that cycle.
- State WR:
  - Word lane: wdata has the data at lane addr[5:2]; wstrb = 4'hf << (addr[5:2]*4).
  - Byte lane: wdata[addr[5:0]*8 +: 8] = wdata1[7:0]; wstrb = 1 << addr[5:0].
  - Unused wdata bits are 0.
  - awvalid and wvalid clear independently on their handshakes; either order, or the same cycle, is legal.
  - On bvalid&&bready, clear bready and go to RESP with resp_err = |bresp.
  - A bvalid seen before both the AW and W handshakes have completed is ignored; bready stays 1.
- State RESP:
  - Pulse resp_valid of the granted client for one cycle.
  - Return to IDLE.
  - A new grant is possible on the next cycle.
- Latency, zero-wait-state slave:
  - Load: req_valid at T gives req_ready at T+1 and resp_valid at T+3.
  - Store: T+3 as well, given single-cycle AW/W/B.
- Client rule: req_valid must drop the cycle after req_ready. The arbiter re-samples only in IDLE.
- Illegal req_size (other than 000 or 010) is treated as word.
- rid/bid are not checked, since only one transaction is outstanding.

Test Plan:
1. Fetch only: req_addr0=0x0000_0048, slave returns rdata word lane 2 = 0xDEADBEEF → araddr=0x48, arsize=3'b010, arid=0; resp_valid0 at T+3 with resp_rdata=0xDEADBEEF, resp_err=0.
2. Exec store byte: addr=0x105, wdata1=0x000000A5 → awaddr=0x105, awsize=0; wstrb=64'h20; wdata[47:40]=0xA5, all other bits 0; resp_valid1 after bvalid.
3. Both clients valid from reset for 4 back-to-back requests → grants alternate 0,1,0,1; no req_ready0 and req_ready1 in the same cycle.
4. Store where awready comes 3 cycles before wready and bvalid arrives 2 cycles early → early bvalid ignored; resp_valid1 only after both handshakes and a subsequent bvalid.
5. Load byte at 0x3F with rdata[511:504]=0x80 and rresp=2'b10 → resp_rdata=0xFFFFFF80, resp_err=1.
6. rstn low while in RD with arvalid=1 → next edge: arvalid=0, rready=0, state IDLE, no resp_valid; a fresh request after reset completes normally.
